// File: rtl/spi_tx_sequencer.sv
// spi_tx_sequencer: byte FIFO feeding a one-byte-at-a-time SPI transfer sequencer.
// Each queued byte is presented on data_sent and announced with a start_bit
// pulse; the master's reply is captured XFER_CYCLES cycles later.
module spi_tx_sequencer #(
    parameter int DEPTH       = 8,
    parameter int XFER_CYCLES = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic [7:0]             rx_data_in,
    output logic                   start_bit,
    output logic [7:0]             data_sent,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(XFER_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, CAPTURE} state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr_next;
    logic [AW:0]   rd_ptr_next;
    logic [AW:0]   level_next;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    // Push/pop decisions and next pointers; the extra pointer MSB separates full from empty.
    always_comb begin
        push        = wr_en && !full;
        pop         = (state == IDLE) && !empty;
        wr_ptr_next = wr_ptr + (AW+1)'(push);
        rd_ptr_next = rd_ptr + (AW+1)'(pop);
        level_next  = wr_ptr_next - rd_ptr_next;
    end

    // Pointers and registered occupancy flags; a write seen while full is dropped and remembered.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            level  <= level_next;
            full   <= (level_next == (AW+1)'(DEPTH));
            empty  <= (level_next == '0);
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Byte storage; contents are meaningful only between the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Sequencer registers: state, transfer down-counter, outgoing byte and captured reply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            data_sent <= 8'h00;
            rx_data   <= 8'h00;
        end else begin
            state <= state_next;
            if (pop) begin
                data_sent <= mem[rd_ptr[AW-1:0]];
            end
            if (state == START) begin
                cnt <= CW'(XFER_CYCLES - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - CW'(1);
            end
            // Sample on the edge into CAPTURE so rx_data is already valid while rx_valid is high.
            if (state == WAIT && cnt == '0) begin
                rx_data <= rx_data_in;
            end
        end
    end

    // Next-state logic and the one-cycle strobes decoded from the current state.
    always_comb begin
        state_next = state;
        start_bit  = 1'b0;
        rx_valid   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = START;
                end
            end
            START: begin
                start_bit  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                rx_valid   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// tb_spi_tx_sequencer: randomized bench comparing spi_tx_sequencer against a
// queue-based reference model, plus directed scenario checks.
module tb_spi_tx_sequencer;
    localparam int DEPTH = 8;
    localparam int XFER  = 40;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int VW    = 22 + LW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic [7:0]    rx_data_in;
    logic          start_bit;
    logic [7:0]    data_sent;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          busy;
    logic          overflow;

    spi_tx_sequencer #(.DEPTH(DEPTH), .XFER_CYCLES(XFER)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rx_data_in(rx_data_in),
        .start_bit(start_bit), .data_sent(data_sent), .rx_data(rx_data), .rx_valid(rx_valid),
        .full(full), .empty(empty), .level(level), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: queue of pending bytes plus the age of the running transfer
    // (-1 idle, 0 start cycle, XFER+1 capture cycle).
    logic [7:0] mq[$];
    int         age;
    logic [7:0] m_sent;
    logic [7:0] m_rx;
    logic       m_ovf;
    bit         rx_fixed;

    logic [7:0] sent[$];
    logic [7:0] exp_bytes[$];

    function automatic void model_step(logic r, logic w, logic [7:0] d, logic [7:0] rin);
        int n = mq.size();
        if (r) begin
            mq.delete();
            age = -1; m_sent = 8'h00; m_rx = 8'h00; m_ovf = 1'b0;
            return;
        end
        if (w && n == DEPTH) m_ovf = 1'b1;
        if (age == XFER) m_rx = rin;
        if (age == -1 && n > 0) begin
            m_sent = mq.pop_front();
            age = 0;
        end else if (age == XFER + 1) begin
            age = -1;
        end else if (age >= 0) begin
            age++;
        end
        if (w && n < DEPTH) mq.push_back(d);
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {age == 0, m_sent, age == XFER + 1, m_rx, mq.size() == DEPTH,
                mq.size() == 0, LW'(mq.size()), age >= 0, m_ovf};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {start_bit, data_sent, rx_valid, rx_data, full, empty, level, busy, overflow};
    endfunction

    // One clock: drive inputs, advance the model over the same edge, settle at the falling edge.
    task automatic tick(input logic r, input logic w, input logic [7:0] d);
        rst = r; wr_en = w; wr_data = d;
        model_step(r, w, d, rx_data_in);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (start_bit) sent.push_back(data_sent);
        if (age == 0 && !rx_fixed) rx_data_in = 8'($urandom);
    endtask

    // Reset, start a preamble transfer (0xEE), then queue n bytes behind it while it runs.
    task automatic preload(input int n, input bit counting);
        logic [7:0] d;
        exp_bytes.delete();
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'hEE);
        repeat (3) tick(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < n; i++) begin
            d = counting ? 8'(i + 1) : 8'($urandom_range(0, 254));
            exp_bytes.push_back(d);
            tick(1'b0, 1'b1, d);
        end
        sent.delete();
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 8'h77);
        checks++;
        if (obs_vec() !== {1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, LW'(0), 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_values: got %h, expected %h", obs_vec(),
                {1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, LW'(0), 1'b0, 1'b0});
        end
        tick(1'b0, 1'b0, 8'h00);
        checks++;
        if (level !== LW'(0) || empty !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_write_priority: level=%0d empty=%b busy=%b, expected 0/1/0",
                level, empty, busy);
        end
    endtask

    task automatic test_single_byte();
        int t_wr, t_start, t_rx;
        logic [7:0] ds_at_start, rx_at_valid;
        t_start = -1; t_rx = -1; ds_at_start = 8'h00; rx_at_valid = 8'h00;
        rx_fixed = 1'b1; rx_data_in = 8'h3C;
        sent.delete();
        t_wr = cyc;
        tick(1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < XFER + 8; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL single_cycle %0d: got %h, expected %h", cyc, obs_vec(), exp_vec());
            end
            if (start_bit && t_start < 0) begin t_start = cyc; ds_at_start = data_sent; end
            if (rx_valid && t_rx < 0) begin t_rx = cyc; rx_at_valid = rx_data; end
            tick(1'b0, 1'b0, 8'h00);
        end
        checks++;
        if (t_start - t_wr !== 2) begin
            errors++; $display("FAIL single_start_latency: got %0d, expected 2", t_start - t_wr);
        end
        checks++;
        if (ds_at_start !== 8'hA5) begin
            errors++; $display("FAIL single_data_sent: got %h, expected a5", ds_at_start);
        end
        checks++;
        if (t_start < 0 || t_rx - t_start !== XFER + 1) begin
            errors++; $display("FAIL single_rx_latency: got %0d, expected %0d", t_rx - t_start, XFER + 1);
        end
        checks++;
        if (rx_at_valid !== 8'h3C || rx_data !== 8'h3C) begin
            errors++; $display("FAIL single_rx_data: got %h then %h, expected 3c", rx_at_valid, rx_data);
        end
        checks++;
        if (sent.size() != 1 || busy !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL single_done: sent=%0d busy=%b empty=%b, expected 1/0/1",
                sent.size(), busy, empty);
        end
        rx_fixed = 1'b0;
    endtask

    task automatic test_fill_drain();
        int starts[$];
        preload(8, 1'b1);
        checks++;
        if (level !== LW'(DEPTH) || full !== 1'b1) begin
            errors++; $display("FAIL fill_full: level=%0d full=%b, expected 8/1", level, full);
        end
        for (int i = 0; i < 9 * (XFER + 3); i++) begin
            tick(1'b0, 1'b0, 8'h00);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL fill_cycle %0d: got %h, expected %h", cyc, obs_vec(), exp_vec());
            end
            if (start_bit) starts.push_back(cyc);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= sent.size() || sent[i] !== 8'(i + 1)) begin
                errors++; $display("FAIL drain_order[%0d]: got %h, expected %h", i,
                    (i < sent.size()) ? sent[i] : 8'hxx, 8'(i + 1));
            end
        end
        for (int i = 1; i < starts.size(); i++) begin
            checks++;
            if (starts[i] - starts[i - 1] !== XFER + 3) begin
                errors++; $display("FAIL drain_spacing[%0d]: got %0d, expected %0d", i,
                    starts[i] - starts[i - 1], XFER + 3);
            end
        end
        checks++;
        if (sent.size() != 8 || empty !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL drain_end: sent=%0d empty=%b busy=%b, expected 8/1/0",
                sent.size(), empty, busy);
        end
    endtask

    task automatic test_overflow();
        int guard;
        preload(8, 1'b0);
        tick(1'b0, 1'b1, 8'hFF);
        checks++;
        if (overflow !== 1'b1 || level !== LW'(DEPTH)) begin
            errors++; $display("FAIL overflow_flag: overflow=%b level=%0d, expected 1/8", overflow, level);
        end
        // Keep writing while full, across the edge where the FSM pops: that write is still dropped.
        guard = 0;
        while (mq.size() == DEPTH && guard < 2 * XFER) begin
            tick(1'b0, 1'b1, 8'hFF);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL overflow_hold_cycle %0d: got %h, expected %h", cyc, obs_vec(), exp_vec());
            end
            guard++;
        end
        checks++;
        if (guard >= 2 * XFER || level !== LW'(DEPTH - 1)) begin
            errors++; $display("FAIL overflow_pop_drop: level=%0d guard=%0d, expected level 7", level, guard);
        end
        for (int i = 0; i < 9 * (XFER + 3); i++) begin
            tick(1'b0, 1'b0, 8'h00);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL overflow_cycle %0d: got %h, expected %h", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (sent != exp_bytes || overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_sent: got %0d bytes %p overflow=%b, expected %p overflow=1",
                sent.size(), sent, overflow, exp_bytes);
        end
    endtask

    task automatic test_push_pop();
        int guard;
        logic [7:0] b;
        preload(3, 1'b0);
        guard = 0;
        while (age != -1 && guard < XFER + 10) begin
            tick(1'b0, 1'b0, 8'h00);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL pushpop_wait_cycle %0d: got %h, expected %h", cyc, obs_vec(), exp_vec());
            end
            guard++;
        end
        checks++;
        if (level !== LW'(3) || busy !== 1'b0) begin
            errors++; $display("FAIL pushpop_pre: level=%0d busy=%b, expected 3/0", level, busy);
        end
        b = 8'($urandom_range(0, 254));
        exp_bytes.push_back(b);
        tick(1'b0, 1'b1, b);
        checks++;
        if (level !== LW'(3) || busy !== 1'b1) begin
            errors++; $display("FAIL pushpop_level: level=%0d busy=%b, expected 3/1", level, busy);
        end
        for (int i = 0; i < 5 * (XFER + 3); i++) begin
            tick(1'b0, 1'b0, 8'h00);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL pushpop_cycle %0d: got %h, expected %h", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (sent != exp_bytes) begin
            errors++; $display("FAIL pushpop_order: got %p, expected %p", sent, exp_bytes);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit rxv_seen, start_seen;
        rxv_seen = 1'b0; start_seen = 1'b0;
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h5A);
        tick(1'b0, 1'b1, 8'h11);
        tick(1'b0, 1'b1, 8'h22);
        repeat (10) tick(1'b0, 1'b0, 8'h00);
        checks++;
        if (busy !== 1'b1 || level !== LW'(2)) begin
            errors++; $display("FAIL midwait_pre: busy=%b level=%0d, expected 1/2", busy, level);
        end
        tick(1'b1, 1'b0, 8'h00);
        checks++;
        if (level !== LW'(0) || start_bit !== 1'b0 || busy !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL midwait_reset: level=%0d start=%b busy=%b empty=%b, expected 0/0/0/1",
                level, start_bit, busy, empty);
        end
        for (int i = 0; i < XFER + 5; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL midwait_cycle %0d: got %h, expected %h", cyc, obs_vec(), exp_vec());
            end
            if (rx_valid) rxv_seen = 1'b1;
            if (start_bit) start_seen = 1'b1;
        end
        checks++;
        if (rxv_seen || start_seen) begin
            errors++; $display("FAIL midwait_abort: rx_valid seen=%b start seen=%b, expected 0/0",
                rxv_seen, start_seen);
        end
        test_single_byte();
    endtask

    task automatic test_wrap();
        int n, guard;
        bit saw_full, w;
        logic [7:0] d;
        n = 0; guard = 0; saw_full = 1'b0;
        exp_bytes.delete();
        tick(1'b1, 1'b0, 8'h00);
        sent.delete();
        while ((n < 20 || mq.size() != 0 || age != -1) && guard < 4000) begin
            w = (n < 20) && (mq.size() < 3) && ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
            if (w) begin exp_bytes.push_back(d); n++; end
            tick(1'b0, w, d);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL wrap_cycle %0d: got %h, expected %h", cyc, obs_vec(), exp_vec());
            end
            if (full) saw_full = 1'b1;
            guard++;
        end
        checks++;
        if (guard >= 4000 || sent != exp_bytes || saw_full) begin
            errors++; $display("FAIL wrap_order: sent %0d bytes, expected 20, full seen=%b, guard=%0d",
                sent.size(), saw_full, guard);
        end
    endtask

    task automatic test_random();
        logic r, w;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 499) == 0);
            w = ($urandom_range(0, 3) == 0);
            tick(r, w, 8'($urandom));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_cycle %0d: got %h, expected %h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rx_data_in = 8'h00;
        age = -1; m_sent = 8'h00; m_rx = 8'h00; m_ovf = 1'b0; rx_fixed = 1'b0;
        test_reset();
        test_single_byte();
        test_fill_drain();
        test_overflow();
        test_push_pop();
        test_reset_mid_wait();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_tx_sequencer.md
SPI_TX_SEQUENCER -- requirements
Module: spi_tx_sequencer

Interface
REQ-001 Parameter: DEPTH, 8, FIFO depth in bytes; power of two, 2..16.
REQ-002 Parameter: XFER_CYCLES, 40, clk cycles from the start_bit pulse until the master's received byte is stable.
REQ-003 Port: clk  input  1  single clock; all logic on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: wr_en  input  1  push wr_data into the FIFO this cycle.
REQ-006 Port: wr_data  input  8  byte to transmit.
REQ-007 Port: rx_data_in  input  8  received byte from the SPI master.
REQ-008 Port: start_bit  output  1  one-cycle transfer request to the SPI master.
REQ-009 Port: data_sent  output  8  byte presented to the SPI master; held stable for the whole transfer.
REQ-010 Port: rx_data  output  8  captured received byte.
REQ-011 Port: rx_valid  output  1  one-cycle pulse; rx_data is updated this cycle.
REQ-012 Port: full  output  1  FIFO holds DEPTH bytes.
REQ-013 Port: empty  output  1  FIFO holds 0 bytes.
REQ-014 Port: level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 Port: busy  output  1  FSM is not in IDLE.
REQ-016 Port: overflow  output  1  sticky flag set by a dropped write.

Function
REQ-017 FIFO: circular buffer; read and write pointers wrap modulo DEPTH; full, empty and level are registered and derived from the pointers.
REQ-018 Write: accepted at the edge when wr_en=1 and full=0, sampled before the edge.
REQ-019 Write while full: byte dropped, FIFO unchanged, overflow set to 1; this applies even if a pop happens in the same cycle.
REQ-020 Simultaneous accepted write and pop: both pointers advance and level is unchanged.
REQ-021 FSM states: IDLE, START, WAIT, CAPTURE.
REQ-022 IDLE, empty=0: pop the head byte into data_sent and go to START at the next edge.
REQ-023 IDLE, empty=1: remain in IDLE.
REQ-024 START: start_bit=1 for exactly this one cycle; load the down-counter with XFER_CYCLES-1; go to WAIT.
REQ-025 WAIT: decrement the counter each cycle; when it reaches 0, go to CAPTURE; WAIT lasts exactly XFER_CYCLES cycles.
REQ-026 CAPTURE: rx_data <= rx_data_in and rx_valid=1 for this one cycle; go to IDLE.
REQ-027 Latency:
  - start_bit goes high 2 cycles after an accepted write to an empty FIFO with the FSM in IDLE.
  - rx_valid goes high XFER_CYCLES+1 cycles after start_bit.
REQ-028 Back-to-back: after CAPTURE, the next start_bit occurs 2 cycles later if the FIFO is non-empty; transfers never overlap.
REQ-029 start_bit=0 in all states other than START; rx_valid=0 in all states other than CAPTURE.
REQ-030 data_sent changes only on the IDLE->START transition.
REQ-031 rx_data holds its value between captures.
REQ-032 busy=1 in START, WAIT and CAPTURE.

Reset
REQ-033 On rst=1 at an edge:
  - FSM goes to IDLE and both pointers to 0.
  - level=0, empty=1, full=0, overflow=0.
  - start_bit=0, rx_valid=0, data_sent=8'h00, rx_data=8'h00.
REQ-034 Reset mid-transfer aborts the transfer with no rx_valid, and discards all queued bytes.
REQ-035 rst has priority over wr_en in the same cycle; the write is not accepted.

Verification
REQ-036 Single byte: write 8'hA5 in IDLE -> start_bit pulse 2 cycles later with data_sent=8'hA5; rx_data_in=8'h3C -> rx_valid pulse XFER_CYCLES+1 cycles after start_bit with rx_data=8'h3C.
REQ-037 Fill and drain: write 8'h01..8'h08 back-to-back -> full=1 and level=8; 8 transfers in order 01..08, each start_bit spaced XFER_CYCLES+3 cycles apart; ends with empty=1 and busy=0.
REQ-038 Overflow: with the FIFO full, write 8'hFF -> overflow=1, level stays 8, and 8'hFF is never sent.
REQ-039 Simultaneous push/pop: level=3 in IDLE plus a write in the same cycle -> level stays 3 and FIFO order is preserved.
REQ-040 Reset mid-WAIT: rst for 1 cycle -> no rx_valid, level=0, start_bit=0; a new write afterwards behaves as in REQ-036.
REQ-041 Pointer wrap: push and pop 20 bytes with occupancy never exceeding 3 -> every byte is sent in order and full never asserts.
